// File: rtl/s27_bist_ctrl_if.sv
// Bundle between the s27 BIST wrapper and its test controller / core.
// master = test controller plus core response; slave = the BIST wrapper.
interface s27_bist_ctrl_if;
  logic        start;
  logic        abort;
  logic        resp_in;
  logic [3:0]  pat_out;
  logic        dut_init;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] pat_cnt;

  modport master (
    output start, abort, resp_in,
    input  pat_out, dut_init, busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, abort, resp_in,
    output pat_out, dut_init, busy, done, pass, signature, pat_cnt
  );
endinterface

// File: rtl/s27_bist_ctrl.sv
// BIST wrapper for the s27 core: a 4-bit LFSR drives G0..G3 and a 16-bit
// serial MISR compacts G17, sequenced by an IDLE/INIT/RUN/CHECK/DONE FSM.
module s27_bist_ctrl #(
  parameter int unsigned NUM_PAT    = 64,
  parameter logic [3:0]  SEED       = 4'h1,
  parameter int unsigned INIT_CYC   = 2,
  parameter logic [15:0] MISR_POLY  = 16'h1021,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input logic             clk,
  input logic             rst,
  s27_bist_ctrl_if.slave  bus
);

  // An all-zero LFSR would lock up, so a zero seed is remapped.
  localparam logic [3:0]  SEED_EFF  = (SEED == 4'h0) ? 4'h1 : SEED;
  localparam logic [3:0]  INIT_LAST = 4'(INIT_CYC - 1);
  localparam logic [15:0] PAT_LAST  = 16'(NUM_PAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  lfsr_q, lfsr_d;
  logic [15:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  init_q, init_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dut_init_q, dut_init_d;

  function automatic logic [3:0] lfsr_step(input logic [3:0] l);
    return {l[2:0], l[3] ^ l[2]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic r);
    logic fb;
    fb = s[15] ^ r;
    return {s[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = INIT;
          lfsr_d  = SEED_EFF;
          sig_d   = 16'h0000;
          cnt_d   = 16'h0000;
          init_d  = 4'h0;
          pass_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      INIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          init_d = init_q + 4'h1;
          if (init_q == INIT_LAST) begin
            state_d = RUN;
          end else begin
            state_d = INIT;
          end
        end
      end
      RUN: begin
        // Abort freezes the partial signature and pattern count.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          lfsr_d = lfsr_step(lfsr_q);
          sig_d  = misr_step(sig_q, bus.resp_in);
          cnt_d  = cnt_q + 16'h0001;
          if (cnt_q == PAT_LAST) begin
            state_d = CHECK;
          end else begin
            state_d = RUN;
          end
        end
      end
      CHECK: begin
        pass_d  = (sig_q == GOLDEN_SIG);
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d == INIT) || (state_d == RUN) || (state_d == CHECK);
    done_d     = (state_d == DONE);
    dut_init_d = (state_d == INIT);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED_EFF;
      sig_q      <= 16'h0000;
      cnt_q      <= 16'h0000;
      init_q     <= 4'h0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dut_init_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      sig_q      <= sig_d;
      cnt_q      <= cnt_d;
      init_q     <= init_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dut_init_q <= dut_init_d;
    end
  end

  assign bus.pat_out   = lfsr_q;
  assign bus.signature = sig_q;
  assign bus.pat_cnt   = cnt_q;
  assign bus.pass      = pass_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dut_init  = dut_init_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Randomized bench for s27_bist_ctrl: a run-level reference model of instance A
// is compared every cycle; instance B pins the MISR arithmetic with literals.
module tb_s27_bist_ctrl;

  localparam int          NP     = 64;
  localparam int          IC     = 2;
  localparam logic [15:0] GOLD_A = 16'h0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  s27_bist_ctrl_if ifc_a ();
  s27_bist_ctrl_if ifc_b ();

  s27_bist_ctrl #(.NUM_PAT(64), .SEED(4'h1), .INIT_CYC(2), .MISR_POLY(16'h1021),
                  .GOLDEN_SIG(16'h0001))
    dut_a (.clk(clk), .rst(rst), .bus(ifc_a));

  s27_bist_ctrl #(.NUM_PAT(2), .SEED(4'h1), .INIT_CYC(2), .MISR_POLY(16'h1021),
                  .GOLDEN_SIG(16'h2042))
    dut_b (.clk(clk), .rst(rst), .bus(ifc_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern k of the sequence: the seed advanced k times by the x^4+x^3+1 shift.
  function automatic logic [3:0] lfsr_after(input logic [3:0] seed, input int k);
    logic [3:0] l;
    l = seed;
    for (int i = 0; i < k; i++) l = {l[2:0], l[3] ^ l[2]};
    return l;
  endfunction

  // Signature after compacting the first n response bits from zero.
  function automatic logic [15:0] misr_fold(input logic [63:0] bits, input int n);
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      if (s[15] ^ bits[i]) s = {s[14:0], 1'b0} ^ 16'h1021;
      else                 s = {s[14:0], 1'b0};
    end
    return s;
  endfunction

  // Reference model of A: phase 0 idle, 1 active, 2 done; m_t cycles into the active run.
  int          m_phase = 0;
  int          m_t     = 0;
  int          m_n     = 0;
  logic [63:0] m_bits  = 64'h0;
  bit          m_pass  = 1'b0;
  bit          cmp_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_n = 0; m_bits = 64'h0; m_pass = 1'b0; cmp_en = 1'b1;
    end else if (cmp_en) begin
      if (m_phase == 1) begin
        if (ifc_a.abort && m_t < IC + NP) m_phase = 0;
        else if (m_t < IC) m_t++;
        else if (m_t < IC + NP) begin
          m_bits[m_n] = ifc_a.resp_in; m_n++; m_t++;
        end else begin
          m_phase = 2;
          m_pass  = (misr_fold(m_bits, m_n) == GOLD_A);
        end
      end else if (ifc_a.start) begin
        m_phase = 1; m_t = 0; m_n = 0; m_bits = 64'h0; m_pass = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",      ifc_a.busy,      m_phase == 1);
      check("done",      ifc_a.done,      m_phase == 2);
      check("dut_init",  ifc_a.dut_init,  (m_phase == 1) && (m_t < IC));
      check("pass",      ifc_a.pass,      m_pass);
      check("pat_cnt",   ifc_a.pat_cnt,   m_n);
      check("pat_out",   ifc_a.pat_out,   lfsr_after(4'h1, m_n));
      check("signature", ifc_a.signature, misr_fold(m_bits, m_n));
    end
  end

  bit rand_resp = 1'b1;

  task automatic step();
    if (rand_resp) ifc_a.resp_in = 1'($urandom % 2);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && !ifc_a.done; n++) step();
    check("done_reached", ifc_a.done, 1'b1);
  endtask

  logic [3:0] seq [16];
  int         ninit;
  int         nwait;

  initial begin
    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    rst = 1'b1;
    ifc_a.start = 1'b0; ifc_a.abort = 1'b0; ifc_a.resp_in = 1'b0;
    ifc_b.start = 1'b0; ifc_b.abort = 1'b0; ifc_b.resp_in = 1'b0;

    // Hand-computed values pinning the model's helpers.
    check("model_lfsr6",  lfsr_after(4'h1, 6),  4'hD);
    check("model_lfsr15", lfsr_after(4'h1, 15), 4'h1);
    check("model_misr1",  misr_fold(64'h1, 1),  16'h1021);
    check("model_misr2",  misr_fold(64'h1, 2),  16'h2042);

    step(); step();
    rst = 1'b0;
    check("rst_pat_out", ifc_a.pat_out, 4'h1);
    check("rst_sig",     ifc_a.signature, 16'h0000);
    check("rst_busy",    ifc_a.busy, 1'b0);

    // MISR arithmetic on B: responses 1 then 0.
    ifc_b.start = 1'b1; step(); ifc_b.start = 1'b0;
    step(); step();
    ifc_b.resp_in = 1'b1; step();
    check("b_sig1", ifc_b.signature, 16'h1021);
    ifc_b.resp_in = 1'b0; step();
    check("b_sig2", ifc_b.signature, 16'h2042);
    check("b_done_early", ifc_b.done, 1'b0);
    step();
    check("b_done", ifc_b.done, 1'b1);
    check("b_pass", ifc_b.pass, 1'b1);

    // LFSR sequence, then a start pulse mid-run that must be ignored.
    ifc_a.start = 1'b1; step(); ifc_a.start = 1'b0;
    step(); step();
    for (int i = 0; i < 16; i++) begin
      check("lfsr_seq", ifc_a.pat_out, seq[i]);
      step();
    end
    ifc_a.start = 1'b1; step(); ifc_a.start = 1'b0;
    check("start_in_run_cnt", ifc_a.pat_cnt, 16'd17);
    wait_done(200);
    check("run_cnt", ifc_a.pat_cnt, 16'd64);

    // Abort in DONE is ignored.
    ifc_a.abort = 1'b1; step(); ifc_a.abort = 1'b0;
    check("abort_done", ifc_a.done, 1'b1);

    // Restart from DONE.
    ifc_a.start = 1'b1; step(); ifc_a.start = 1'b0;
    check("restart_sig",  ifc_a.signature, 16'h0000);
    check("restart_cnt",  ifc_a.pat_cnt, 16'd0);
    check("restart_pat",  ifc_a.pat_out, 4'h1);
    check("restart_done", ifc_a.done, 1'b0);
    ninit = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifc_a.dut_init) ninit++;
      step();
    end
    check("dut_init_len", ninit, 2);

    // Abort at pat_cnt 10.
    nwait = 0;
    while (ifc_a.pat_cnt != 16'd10 && nwait < 100) begin step(); nwait++; end
    check("reach_cnt10", ifc_a.pat_cnt, 16'd10);
    ifc_a.abort = 1'b1; step(); ifc_a.abort = 1'b0;
    check("abort_busy", ifc_a.busy, 1'b0);
    check("abort_done0", ifc_a.done, 1'b0);
    check("abort_cnt", ifc_a.pat_cnt, 16'd10);

    // Fail detect: all-zero responses against a nonzero golden value.
    rand_resp = 1'b0; ifc_a.resp_in = 1'b0;
    ifc_a.start = 1'b1; step(); ifc_a.start = 1'b0;
    wait_done(200);
    check("fail_sig",  ifc_a.signature, 16'h0000);
    check("fail_cnt",  ifc_a.pat_cnt, 16'd64);
    check("fail_pass", ifc_a.pass, 1'b0);
    rand_resp = 1'b1;

    // Reset mid-run.
    ifc_a.start = 1'b1; step(); ifc_a.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("mrst_busy",     ifc_a.busy, 1'b0);
    check("mrst_done",     ifc_a.done, 1'b0);
    check("mrst_pass",     ifc_a.pass, 1'b0);
    check("mrst_dut_init", ifc_a.dut_init, 1'b0);
    check("mrst_sig",      ifc_a.signature, 16'h0000);
    check("mrst_cnt",      ifc_a.pat_cnt, 16'd0);
    check("mrst_pat",      ifc_a.pat_out, 4'h1);

    // Random soak of start/abort/reset traffic.
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom % 200) == 0;
      ifc_a.start = ($urandom % 6) == 0;
      ifc_a.abort = ($urandom % 50) == 0;
      step();
    end
    rst = 1'b0; ifc_a.start = 1'b0; ifc_a.abort = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s27_bist_ctrl.md
Name: s27_bist_ctrl

Overview:
- Built-in self-test wrapper stage for the s27 sequential core.
- Upstream side: a 4-bit LFSR test-pattern generator drives the core's primary inputs G0..G3.
- Downstream side: a 16-bit serial MISR compacts the core's single output G17 into a signature.
- A control FSM sequences init, pattern run and signature check, then reports pass/fail to the test controller.

Parameters:
- NUM_PAT, 64, number of patterns applied and responses compacted (2..65535).
- SEED, 4'h1, LFSR load value. A value of 0 is replaced by 4'h1.
- INIT_CYC, 2, cycles dut_init is held high before the run (1..15).
- MISR_POLY, 16'h1021, MISR feedback polynomial.
- GOLDEN_SIG, 16'h0000, expected final signature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a test. Sampled only in IDLE or DONE.
- abort  in  1  cancel a test. Effective only in INIT or RUN.
- pat_out  out  4  pattern to core: bit0→G0, bit1→G1, bit2→G2, bit3→G3.
- resp_in  in  1  core response (G17).
- dut_init  out  1  active-high core init request. Integrator drives core rstn/setn low from it.
- busy  out  1  high in INIT, RUN, CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1: signature == GOLDEN_SIG.
- signature  out  16  current MISR contents.
- pat_cnt  out  16  patterns applied so far in this run.

Behaviour:
- Fully synchronous; every register updates on the clk rising edge.
- rst (any state, including mid-run) takes priority over everything. Next state IDLE; lfsr=SEED, signature=0, pat_cnt=0, init counter=0; busy=0, done=0, pass=0, dut_init=0.
- pat_out is the LFSR register directly, so it reads SEED after reset.
- LFSR (x^4+x^3+1, period 15): next = {lfsr[2:0], lfsr[3]^lfsr[2]}. Advances only in RUN.
- MISR: fb = signature[15] ^ resp_in; next = (signature<<1) ^ (fb ? MISR_POLY : 0). Updates only in RUN; width is exactly 16 bits, and the MSB shifted out is discarded.
- FSM states: IDLE, INIT, RUN, CHECK, DONE.
  - IDLE: start=1 → INIT. On that same edge: lfsr←SEED, signature←0, pat_cnt←0, init counter←0.
  - INIT: dut_init=1, pat_out=SEED held. Init counter increments each cycle. After INIT_CYC cycles → RUN (counter==INIT_CYC-1 at the edge). abort=1 → IDLE.
  - RUN: pattern k is on pat_out during RUN cycle k (k=0 is SEED). resp_in is sampled at the end of that same cycle; the core's combinational path G0..3→G17 is assumed to settle within the cycle. Each cycle: MISR update, LFSR advance, pat_cnt+1. At the edge where pat_cnt==NUM_PAT-1 → CHECK, so exactly NUM_PAT responses are compacted. abort=1 → IDLE with no MISR/LFSR update on that edge; signature keeps its partial value and done stays 0.
  - CHECK: one cycle. pass←(signature==GOLDEN_SIG) → DONE.
  - DONE: done=1; signature, pat_cnt and pass held. start=1 → INIT with the same clears as from IDLE, and done/pass drop on that edge.
- start while busy: ignored. abort outside INIT/RUN: ignored. start and abort both high in IDLE/DONE: start wins.
- dut_init is registered: high exactly INIT_CYC cycles, starting the cycle after start is sampled.
- Latency from start sampled to done=1 is INIT_CYC + NUM_PAT + 1 cycles.
- pat_cnt does not wrap within a run; NUM_PAT ≤ 65535 guarantees this.

Test Plan:
- Reset: drive rst mid-RUN (NUM_PAT=64) → next cycle busy=0, done=0, pass=0, dut_init=0, signature=16'h0000, pat_cnt=0, pat_out=4'h1.
- LFSR sequence: SEED=1, start → during RUN, pat_out = 1,2,4,9,3,6,D,A,5,… Pattern 15 equals 4'h1 again; 4'h0 never appears.
- MISR arithmetic: NUM_PAT=2, GOLDEN_SIG=16'h2042, resp_in=1 then 0 → signature 16'h1021 then 16'h2042. done=1 with pass=1 exactly INIT_CYC+3 cycles after start.
- Fail detect: NUM_PAT=64, resp_in held 0, GOLDEN_SIG=16'h0001 → signature=0, pat_cnt=64, done=1, pass=0.
- Control corners: start pulsed during RUN → no restart, pat_cnt continues. abort at pat_cnt=10 → IDLE, done=0, pat_cnt=10. abort in DONE → ignored.
- Restart from DONE: start in DONE with prior signature≠0 → signature=0, pat_cnt=0, pat_out=SEED, done=0. dut_init is high for exactly INIT_CYC=2 cycles.
